// File: rtl/fetch_pc_if.sv
// Bundle between the fetch PC stage and its surroundings (PC-select, icache, decode).
// slave = the fetch stage itself, master = the environment driving it.
interface fetch_pc_if;
    logic [1:0]  pc_sel;
    logic        flush;
    logic        stall;
    logic [31:0] alu_target;
    logic [31:0] icache_dout;
    logic [31:0] icache_addr;
    logic        icache_re;
    logic [31:0] inst_if;
    logic [31:0] pc_if;
    logic        valid_if;
    logic [31:0] prev_inst;
    logic [31:0] flush_count;
    logic [31:0] inst_count;

    modport slave (
        input  pc_sel, flush, stall, alu_target, icache_dout,
        output icache_addr, icache_re, inst_if, pc_if, valid_if,
               prev_inst, flush_count, inst_count
    );

    modport master (
        output pc_sel, flush, stall, alu_target, icache_dout,
        input  icache_addr, icache_re, inst_if, pc_if, valid_if,
               prev_inst, flush_count, inst_count
    );
endinterface

// File: rtl/fetch_pc_stage.sv
// IF stage: PC register, icache read address, IF->ID instruction and prev_inst.
// Define FETCH_PERF_COUNT_EN to build the flush/instruction performance counters.
module fetch_pc_stage #(
    parameter logic [31:0] RESET_PC = 32'h4000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    fetch_pc_if.slave   io_fetch
);
    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_BOOT  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] r_prev_inst;
    logic [31:0] w_next_pc;
    logic [31:0] w_target;
    logic [31:0] w_inst;
    logic        w_re;
    logic        w_kill;
    logic        w_valid;
    logic        w_prev_en;

    assign w_target = io_fetch.alu_target & ~32'h0000_0003;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RESET;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_next_pc    = r_pc;
        w_re         = 1'b0;
        w_kill       = 1'b1;
        case (r_state)
            ST_RESET: begin
                w_state_next = ST_BOOT;
            end
            ST_BOOT: begin
                w_state_next = ST_RUN;
                w_next_pc    = RESET_PC;
                w_re         = 1'b1;
            end
            ST_RUN: begin
                // A flush redirects even while stalled, so it must also re-enable the read.
                w_re   = io_fetch.flush | ~io_fetch.stall;
                w_kill = io_fetch.flush | (io_fetch.pc_sel == 2'b00);
                if (io_fetch.flush) begin
                    w_next_pc = w_target;
                end else if (io_fetch.stall) begin
                    w_next_pc = r_pc;
                end else begin
                    case (io_fetch.pc_sel)
                        2'b00:   w_next_pc = r_pc;
                        2'b01:   w_next_pc = w_target;
                        default: w_next_pc = r_pc + 32'd4;
                    endcase
                end
            end
            default: begin
                w_state_next = ST_RESET;
            end
        endcase
    end

    assign w_valid   = ~w_kill;
    assign w_inst    = w_kill ? NOP_INST : io_fetch.icache_dout;
    assign w_prev_en = ~io_fetch.stall | io_fetch.flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= RESET_PC;
            r_prev_inst <= NOP_INST;
        end else begin
            r_pc <= w_next_pc;
            if (w_prev_en) begin
                r_prev_inst <= w_inst;
            end
        end
    end

    assign io_fetch.icache_addr = w_next_pc;
    assign io_fetch.icache_re   = w_re;
    assign io_fetch.inst_if     = w_inst;
    assign io_fetch.pc_if       = r_pc;
    assign io_fetch.valid_if    = w_valid;
    assign io_fetch.prev_inst   = r_prev_inst;

`ifdef FETCH_PERF_COUNT_EN
    // Index 0 counts redirects, index 1 counts instructions actually accepted by decode.
    logic [1:0] w_cnt_inc;
    assign w_cnt_inc[0] = (r_state == ST_RUN) & io_fetch.flush;
    assign w_cnt_inc[1] = w_valid & ~io_fetch.stall;

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        logic [31:0] r_cnt;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= 32'd0;
            end else if (w_cnt_inc[gi]) begin
                r_cnt <= r_cnt + 32'd1;
            end
        end
    end

    assign io_fetch.flush_count = g_cnt[0].r_cnt;
    assign io_fetch.inst_count  = g_cnt[1].r_cnt;
`else
    assign io_fetch.flush_count = 32'd0;
    assign io_fetch.inst_count  = 32'd0;
`endif
endmodule

// File: tb/tb_fetch_pc_stage.sv
// Randomized scoreboard bench for fetch_pc_stage against a cycle-level reference model.
module tb_fetch_pc_stage;
    localparam logic [31:0] RESET_PC = 32'h4000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    fetch_pc_if bus();

    fetch_pc_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .io_fetch (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5C3, a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Synchronous-read icache: dout holds while re is low.
    always @(posedge clk) begin
        if (bus.icache_re) bus.icache_dout <= mem_fn(bus.icache_addr);
    end

    typedef struct {
        int          cyc;
        logic        chk_addr;
        logic [31:0] addr;
        logic        re;
        logic [31:0] inst;
        logic [31:0] pc;
        logic        valid;
        logic [31:0] prev;
        logic [31:0] fc;
        logic [31:0] ic;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    // Reference model: phase 0 = held in reset, 1 = boot fetch, 2 = running.
    int          m_phase;
    logic [31:0] m_pc, m_prev, m_dout, m_fc, m_ic;

    task automatic check(input string name, input int c, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, c, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_pc    = RESET_PC;
        m_prev  = NOP;
        m_fc    = 32'd0;
        m_ic    = 32'd0;
    endtask

    task automatic cycle(input logic rst, input logic [1:0] sel, input logic fl,
                         input logic st, input logic [31:0] tgt);
        exp_t        e;
        logic        killed;
        logic [31:0] npc;
        @(posedge clk);
        #1;
        rst_n          = rst;
        bus.pc_sel     = sel;
        bus.flush      = fl;
        bus.stall      = st;
        bus.alu_target = tgt;
        cyc++;
        if (!rst) model_reset();
        e.cyc  = cyc;
        e.pc   = m_pc;
        e.prev = m_prev;
`ifdef FETCH_PERF_COUNT_EN
        e.fc = m_fc;
        e.ic = m_ic;
`else
        e.fc = 32'd0;
        e.ic = 32'd0;
`endif
        npc = m_pc;
        if (m_phase == 0) begin
            e.chk_addr = 1'b0; e.addr = 32'd0; e.re = 1'b0; e.inst = NOP; e.valid = 1'b0;
        end else if (m_phase == 1) begin
            e.chk_addr = 1'b1; e.addr = RESET_PC; e.re = 1'b1; e.inst = NOP; e.valid = 1'b0;
        end else begin
            killed = fl || (sel == 2'b00);
            if (fl)               npc = {tgt[31:2], 2'b00};
            else if (st)          npc = m_pc;
            else if (sel == 2'd0) npc = m_pc;
            else if (sel == 2'd1) npc = {tgt[31:2], 2'b00};
            else                  npc = m_pc + 32'd4;
            e.chk_addr = 1'b1;
            e.addr     = npc;
            e.re       = fl || !st;
            e.inst     = killed ? NOP : m_dout;
            e.valid    = !killed;
        end
        sb.push_back(e);
        if (m_phase == 1) begin
            m_pc   = RESET_PC;
            m_prev = NOP;
            m_dout = mem_fn(RESET_PC);
        end else if (m_phase == 2) begin
            m_pc = npc;
            if (e.re) m_dout = mem_fn(npc);
            if (!st || fl) m_prev = e.inst;
            if (fl) m_fc = m_fc + 32'd1;
            if (e.valid && !st) m_ic = m_ic + 32'd1;
        end
        if (rst && m_phase < 2) m_phase++;
    endtask

    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, 2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 4) == 0), RESET_PC + 32'($urandom_range(0, 4095)));
        end
    endtask

    // Assert reset between edges and check the outputs before any clock edge.
    task automatic reset_mid();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_pc",    cyc, bus.pc_if, RESET_PC);
        check("async_valid", cyc, {31'd0, bus.valid_if}, 32'd0);
        check("async_inst",  cyc, bus.inst_if, NOP);
        check("async_re",    cyc, {31'd0, bus.icache_re}, 32'd0);
        check("async_prev",  cyc, bus.prev_inst, NOP);
        check("async_fcnt",  cyc, bus.flush_count, 32'd0);
        check("async_icnt",  cyc, bus.inst_count, 32'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (e.chk_addr) check("icache_addr", e.cyc, bus.icache_addr, e.addr);
                check("icache_re", e.cyc, {31'd0, bus.icache_re}, {31'd0, e.re});
                check("inst_if",   e.cyc, bus.inst_if, e.inst);
                check("pc_if",     e.cyc, bus.pc_if, e.pc);
                check("valid_if",  e.cyc, {31'd0, bus.valid_if}, {31'd0, e.valid});
                check("prev_inst", e.cyc, bus.prev_inst, e.prev);
                check("flush_cnt", e.cyc, bus.flush_count, e.fc);
                check("inst_cnt",  e.cyc, bus.inst_count, e.ic);
            end
        end
    end

    initial begin : stimulus
        bus.pc_sel      = 2'b10;
        bus.flush       = 1'b0;
        bus.stall       = 1'b0;
        bus.alu_target  = 32'd0;
        bus.icache_dout = 32'd0;
        model_reset();
        m_dout = 32'd0;
        for (int i = 0; i < 3; i++) cycle(1'b0, 2'b10, 1'b0, 1'b0, 32'd0);
        cycle(1'b1, 2'b10, 1'b0, 1'b0, 32'd0);                  // still RESET after release
        cycle(1'b1, 2'b10, 1'b0, 1'b0, 32'd0);                  // BOOT
        for (int i = 0; i < 4; i++) cycle(1'b1, 2'b10, 1'b0, 1'b0, 32'd0);
        cycle(1'b1, 2'b01, 1'b1, 1'b0, 32'h4000_0103);          // redirect to 0x..100
        cycle(1'b1, 2'b10, 1'b0, 1'b0, 32'd0);
        cycle(1'b1, 2'b10, 1'b0, 1'b0, 32'd0);
        cycle(1'b1, 2'b10, 1'b1, 1'b0, 32'h4000_0008);
        cycle(1'b1, 2'b00, 1'b0, 1'b0, 32'd0);                  // refetch at 0x..08
        cycle(1'b1, 2'b10, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 2'b10, 1'b0, 1'b1, 32'd0);
        cycle(1'b1, 2'b10, 1'b0, 1'b0, 32'd0);
        cycle(1'b1, 2'b10, 1'b0, 1'b1, 32'd0);
        cycle(1'b1, 2'b10, 1'b1, 1'b1, 32'h4000_0200);          // flush beats stall
        cycle(1'b1, 2'b10, 1'b0, 1'b0, 32'd0);
        rand_cycles(3000);
        reset_mid();
        cycle(1'b0, 2'b10, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 2'b10, 1'b0, 1'b0, 32'd0);
        cycle(1'b1, 2'b10, 1'b0, 1'b0, 32'd0);
        rand_cycles(1000);
        @(negedge clk);
        @(negedge clk);
        check("sb_drain", cyc, 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
